exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 109 ++++++++++
 tb/tb_exc_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/ERET controller: in the memory stage it picks the highest-priority cause,
// reports it to CP0, waits for the data bus to drain, then redirects fetch.
module exc_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_in_delay_slot,
  input  logic        m_adel_if,
  input  logic        m_ri,
  input  logic        m_ov,
  input  logic        m_sys,
  input  logic        m_bp,
  input  logic        m_adel_ld,
  input  logic        m_ades_st,
  input  logic        m_eret,
  input  logic [31:0] m_badaddr,
  input  logic        cp0_interrupt,
  input  logic [31:0] cp0_epc,
  input  logic        mem_busy,
  input  logic        fetch_ready,
  output logic        exception,
  output logic [5:0]  m_excCode,
  output logic [31:0] excPC,
  output logic [31:0] invalid_addr,
  output logic        isBadAddr,
  output logic        inDelaySlot,
  output logic        ERET2pc,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic        is_idle, has_cause, exc_take, eret_take;

  assign is_idle   = (state_q == IDLE);
  assign has_cause = cp0_interrupt | m_adel_if | m_ri | m_ov | m_sys | m_bp
                   | m_adel_ld | m_ades_st;
  assign exc_take  = is_idle & m_valid & has_cause;
  // An exception always wins over ERET in the same instruction.
  assign eret_take = is_idle & m_valid & m_eret & ~has_cause;

  always_comb begin
    m_excCode    = 6'd0;
    invalid_addr = 32'd0;
    isBadAddr    = 1'b0;
    if (exc_take) begin
      if (cp0_interrupt)  m_excCode = 6'd0;
      else if (m_adel_if) begin
        m_excCode    = 6'd4;
        invalid_addr = m_pc;
        isBadAddr    = 1'b1;
      end
      else if (m_ri)      m_excCode = 6'd10;
      else if (m_ov)      m_excCode = 6'd12;
      else if (m_sys)     m_excCode = 6'd8;
      else if (m_bp)      m_excCode = 6'd9;
      else if (m_adel_ld) begin
        m_excCode    = 6'd4;
        invalid_addr = m_badaddr;
        isBadAddr    = 1'b1;
      end
      else begin
        m_excCode    = 6'd5;
        invalid_addr = m_badaddr;
        isBadAddr    = 1'b1;
      end
    end
  end

  assign exception      = exc_take;
  assign excPC          = exc_take ? m_pc : 32'd0;
  assign inDelaySlot    = exc_take & m_in_delay_slot;
  assign ERET2pc        = eret_take;
  assign flush          = exc_take | eret_take | ~is_idle;
  assign stall          = (state_q == DRAIN);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_valid ? tgt_q : 32'd0;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: if (exc_take | eret_take) begin
        tgt_d   = exc_take ? EXC_VEC : cp0_epc;
        state_d = mem_busy ? DRAIN : REDIRECT;
      end
      DRAIN:    if (!mem_busy) state_d = REDIRECT;
      REDIRECT: if (fetch_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized + directed bench for exc_ctrl against a cause-table reference model.
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid, m_in_delay_slot, m_adel_if, m_ri, m_ov, m_sys, m_bp;
  logic        m_adel_ld, m_ades_st, m_eret, cp0_interrupt, mem_busy, fetch_ready;
  logic [31:0] m_pc, m_badaddr, cp0_epc;
  logic        exception, isBadAddr, inDelaySlot, ERET2pc, flush, stall, redirect_valid;
  logic [5:0]  m_excCode;
  logic [31:0] excPC, invalid_addr, redirect_pc;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_pc(m_pc),
    .m_in_delay_slot(m_in_delay_slot), .m_adel_if(m_adel_if), .m_ri(m_ri),
    .m_ov(m_ov), .m_sys(m_sys), .m_bp(m_bp), .m_adel_ld(m_adel_ld),
    .m_ades_st(m_ades_st), .m_eret(m_eret), .m_badaddr(m_badaddr),
    .cp0_interrupt(cp0_interrupt), .cp0_epc(cp0_epc), .mem_busy(mem_busy),
    .fetch_ready(fetch_ready), .exception(exception), .m_excCode(m_excCode),
    .excPC(excPC), .invalid_addr(invalid_addr), .isBadAddr(isBadAddr),
    .inDelaySlot(inDelaySlot), .ERET2pc(ERET2pc), .flush(flush), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Reference model: phase 0 = accepting, 1 = waiting for bus, 2 = offering target.
  int          ph  = 0;
  logic [31:0] tgt = 32'd0;
  int          codes [8] = '{0, 4, 10, 12, 8, 9, 4, 5};

  function automatic int first_cause();
    logic [7:0] c;
    c = {m_ades_st, m_adel_ld, m_bp, m_sys, m_ov, m_ri, m_adel_if, cp0_interrupt};
    for (int i = 0; i < 8; i++) if (c[i]) return i;
    return -1;
  endfunction

  function automatic logic [108:0] exp_out();
    int k; bit ex, er, bd;
    logic [31:0] inv;
    k   = first_cause();
    ex  = (ph == 0) && m_valid && (k >= 0);
    er  = (ph == 0) && m_valid && m_eret && (k < 0);
    bd  = ex && (k == 1 || k == 6 || k == 7);
    inv = !ex ? 32'd0 : (k == 1) ? m_pc : bd ? m_badaddr : 32'd0;
    return {ex, ex ? 6'(codes[k]) : 6'd0, ex ? m_pc : 32'd0, inv, bd,
            ex & m_in_delay_slot, er, ex | er | (ph != 0), ph == 1, ph == 2,
            (ph == 2) ? tgt : 32'd0};
  endfunction

  function automatic logic [108:0] act_out();
    return {exception, m_excCode, excPC, invalid_addr, isBadAddr, inDelaySlot,
            ERET2pc, flush, stall, redirect_valid, redirect_pc};
  endfunction

  always @(posedge clk) begin
    int k; bit ex, er;
    k  = first_cause();
    ex = (ph == 0) && m_valid && (k >= 0);
    er = (ph == 0) && m_valid && m_eret && (k < 0);
    if (!resetn) begin
      ph = 0; tgt = 32'd0;
    end else if (ph == 0) begin
      if (ex || er) begin
        tgt = ex ? 32'hBFC0_0380 : cp0_epc;
        ph  = mem_busy ? 1 : 2;
      end
    end else if (ph == 1) begin
      if (!mem_busy) ph = 2;
    end else if (fetch_ready) ph = 0;
  end

  task automatic chk(input string name, input logic [108:0] a, input logic [108:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, a, e);
    end
  endtask

  always @(negedge clk) if (cmp_en) chk("model", act_out(), exp_out());

  task automatic clr();
    m_valid = 0; m_in_delay_slot = 0; m_adel_if = 0; m_ri = 0; m_ov = 0; m_sys = 0;
    m_bp = 0; m_adel_ld = 0; m_ades_st = 0; m_eret = 0; cp0_interrupt = 0;
    mem_busy = 0; fetch_ready = 1; m_pc = 0; m_badaddr = 0; cp0_epc = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    clr(); resetn = 0;
    cyc(); cyc();
    resetn = 1;
    cmp_en = 1'b1;
    #2 chk("reset_idle", act_out(), '0);

    // Overflow, bus idle, fetch ready.
    cyc(); m_valid = 1; m_ov = 1; m_pc = 32'h8000_0100;
    #2 chk("ov_exc", {exception, m_excCode, excPC}, {1'b1, 6'd12, 32'h8000_0100});
    cyc(); clr();
    #2 chk("ov_redir", {redirect_valid, redirect_pc, flush}, {1'b1, 32'hBFC0_0380, 1'b1});
    cyc();
    #2 chk("ov_idle", {flush, redirect_valid, stall}, 3'b000);

    // Interrupt outranks RI and load AdEL.
    cyc(); m_valid = 1; cp0_interrupt = 1; m_ri = 1; m_adel_ld = 1; m_badaddr = 32'h44;
    #2 chk("int_code", {exception, m_excCode, isBadAddr, invalid_addr}, {1'b1, 6'd0, 1'b0, 32'd0});
    cyc(); clr();
    cyc();

    // Store AdES with bus busy: three drain cycles.
    cyc(); m_valid = 1; m_ades_st = 1; m_badaddr = 32'h0000_1003; mem_busy = 1;
    #2 chk("ades_code", {m_excCode, invalid_addr, isBadAddr}, {6'd5, 32'h0000_1003, 1'b1});
    cyc(); clr(); mem_busy = 1;
    #2 chk("drain1", {stall, flush, redirect_valid}, 3'b110);
    cyc(); mem_busy = 1;
    #2 chk("drain2", {stall, flush, redirect_valid}, 3'b110);
    cyc(); mem_busy = 0;
    #2 chk("drain3", {stall, flush, redirect_valid}, 3'b110);
    cyc();
    #2 chk("drain_redir", {stall, redirect_valid, redirect_pc}, {2'b01, 32'hBFC0_0380});
    cyc();

    // ERET with fetch back-pressure.
    cyc(); m_valid = 1; m_eret = 1; cp0_epc = 32'h8000_2000; fetch_ready = 0;
    #2 chk("eret_pulse", {ERET2pc, exception, flush}, 3'b101);
    cyc(); clr(); fetch_ready = 0; cp0_epc = 32'h1234_5678;
    #2 chk("eret_hold1", {redirect_valid, redirect_pc}, {1'b1, 32'h8000_2000});
    cyc(); fetch_ready = 0;
    #2 chk("eret_hold2", {redirect_valid, redirect_pc}, {1'b1, 32'h8000_2000});
    cyc(); fetch_ready = 1;
    #2 chk("eret_hold3", {redirect_valid, redirect_pc}, {1'b1, 32'h8000_2000});
    cyc();
    #2 chk("eret_idle", redirect_valid, 1'b0);

    // Fetch AdEL suppresses ERET.
    cyc(); m_valid = 1; m_eret = 1; m_adel_if = 1; m_pc = 32'h8000_0002;
    #2 chk("adelif", {exception, m_excCode, invalid_addr, ERET2pc}, {1'b1, 6'd4, 32'h8000_0002, 1'b0});
    cyc(); clr();
    cyc();

    // Reset mid-REDIRECT, then m_valid low with causes set.
    cyc(); m_valid = 1; m_sys = 1;
    cyc(); clr(); fetch_ready = 0; resetn = 0;
    #2 chk("rst_in_redir", redirect_valid, 1'b1);
    cyc(); resetn = 1;
    #2 chk("rst_all_zero", act_out(), '0);
    cyc(); m_ov = 1; m_ri = 1; cp0_interrupt = 1; m_eret = 1;
    #2 chk("novalid", {exception, ERET2pc, flush}, 3'b000);
    cyc(); clr();
    #2 chk("novalid_next", {flush, redirect_valid}, 2'b00);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      m_valid         = ($urandom_range(0, 1) == 1);
      m_pc            = $urandom; m_badaddr = $urandom; cp0_epc = $urandom;
      m_in_delay_slot = ($urandom_range(0, 1) == 1);
      m_adel_if       = ($urandom_range(0, 15) == 0);
      m_ri            = ($urandom_range(0, 15) == 0);
      m_ov            = ($urandom_range(0, 15) == 0);
      m_sys           = ($urandom_range(0, 15) == 0);
      m_bp            = ($urandom_range(0, 15) == 0);
      m_adel_ld       = ($urandom_range(0, 15) == 0);
      m_ades_st       = ($urandom_range(0, 15) == 0);
      m_eret          = ($urandom_range(0, 5) == 0);
      cp0_interrupt   = ($urandom_range(0, 11) == 0);
      mem_busy        = ($urandom_range(0, 1) == 1);
      fetch_ready     = ($urandom_range(0, 4) < 3);
      resetn          = ($urandom_range(0, 49) != 0);
    end
    cyc();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
